enigma_rotor_stack: RTL and testbench

- Parametrised multi-rotor Enigma scrambler for the ENIGMA_TEST datapath.
- Passes one symbol through N_ROT rotors, forward or reverse, one rotor per cycle, using valid/ready handshakes on input and output.
- Stepping uses odometer-style carry with loadable rotor positions.
- Replaces the fixed two-rotor return path and serves both the entry and the reflected legs of the machine.

---
 rtl/enigma_pkg.sv | 31 +++
 rtl/enigma_rotor_stage.sv | 50 +++++
 rtl/enigma_rotor_stack.sv | 169 ++++++++++++++++
 tb/tb_enigma_rotor_stack.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/enigma_pkg.sv
// Shared definitions for the Enigma rotor stack.
//   ROTOR_W  : wiring of rotors 0..3, values 1..26 (rotor k maps contact c to ROTOR_W[k][c])
//   state_t  : sequencer states of the rotor stack
//   mod_add  : (a + b) mod n for operands already reduced below n
package enigma_pkg;

  localparam int N_ROT_MAX = 4;
  localparam int N_WIRE    = 26;
  // Width of the modular arithmetic helper; covers SYM_W up to 7.
  localparam int ARITH_W   = 8;

  typedef enum logic [1:0] {IDLE, PASS, OUT} state_t;

  localparam int ROTOR_W [N_ROT_MAX][N_WIRE] = '{
    '{10, 7, 4,17,15,24,21,19, 3, 1,13, 9, 6,18,22,20,16,14, 5,23,11, 2,12,26,25, 8},
    '{14,20,26,16,19, 6, 2,15,11,13,23,18, 3,10, 4, 9,22,12, 1, 5,25,21,24, 8, 7,17},
    '{ 2, 4, 6, 8,10,12, 3,16,18,20,24,22,26,14,25, 5, 9,23, 7, 1,11,13,21,19,17,15},
    '{ 5,19,15,22,16,26,10, 1,25,17,21, 9,18, 8,24,12,14, 6,20, 7,11, 4, 3,13,23, 2}
  };

  // Both operands must be < n, so a single conditional subtract suffices.
  function automatic logic [ARITH_W-1:0] mod_add(input logic [ARITH_W-1:0] a,
                                                 input logic [ARITH_W-1:0] b,
                                                 input logic [ARITH_W-1:0] n);
    logic [ARITH_W-1:0] s;
    s = a + b;
    if (s >= n) s = s - n;
    return s;
  endfunction

endpackage

// File: rtl/enigma_rotor_stage.sv
// Combinational single-rotor map, forward or inverse.
//   sym_i       : input symbol 1..N_SYM
//   pos_i       : rotor position 0..N_SYM-1
//   rev_i       : 0 = forward wiring, 1 = inverse wiring
//   rotor_sel_i : which wiring of ROTOR_W to use
//   sym_o       : mapped symbol 1..N_SYM
module enigma_rotor_stage
  import enigma_pkg::*;
#(
  parameter int N_SYM = 26,
  parameter int SYM_W = 5
) (
  input  logic [SYM_W-1:0] sym_i,
  input  logic [SYM_W-1:0] pos_i,
  input  logic             rev_i,
  input  logic [1:0]       rotor_sel_i,
  output logic [SYM_W-1:0] sym_o
);

  logic [ARITH_W-1:0] n, s0, p, neg_p;
  logic [ARITH_W-1:0] c_fwd, w_fwd, res_fwd;
  logic [ARITH_W-1:0] t_rev, c_rev, res_rev;

  always_comb begin
    n     = ARITH_W'(N_SYM);
    s0    = ARITH_W'(sym_i) - ARITH_W'(1);
    p     = ARITH_W'(pos_i);
    // Adding N_SYM-p is subtracting p modulo N_SYM without going negative.
    neg_p = n - p;

    // Forward: contact entered is offset by the position, exit offset removed.
    c_fwd = mod_add(s0, p, n);
    w_fwd = '0;
    for (int i = 0; i < N_WIRE; i++) begin
      if (c_fwd == ARITH_W'(i)) w_fwd = ARITH_W'(ROTOR_W[rotor_sel_i][i]);
    end
    res_fwd = mod_add(w_fwd - ARITH_W'(1), neg_p, n);

    // Inverse: search the wiring table for the contact that produces t_rev.
    t_rev = mod_add(s0, p, n) + ARITH_W'(1);
    c_rev = '0;
    for (int i = 0; i < N_WIRE; i++) begin
      if (ARITH_W'(ROTOR_W[rotor_sel_i][i]) == t_rev) c_rev = ARITH_W'(i);
    end
    res_rev = mod_add(c_rev, neg_p, n);

    sym_o = SYM_W'((rev_i ? res_rev : res_fwd) + ARITH_W'(1));
  end

endmodule

// File: rtl/enigma_rotor_stack.sv
// Multi-rotor Enigma scrambler: one symbol passes through N_ROT rotors,
// one rotor per cycle, with odometer stepping after each valid symbol.
//   clk, rst_n           : clock, synchronous active-low reset
//   in_valid/in_ready    : input handshake for in_sym / in_rev
//   in_rev               : 0 = rotor 0 first (forward), 1 = top rotor first (inverse)
//   out_valid/out_ready  : output handshake for out_sym / out_err
//   out_err              : input symbol was 0 or above N_SYM (out_sym forced to 0)
//   cfg_we/idx/pos       : load one rotor position while idle
//   pos_o                : packed rotor positions, rotor k at [k*SYM_W +: SYM_W]
module enigma_rotor_stack
  import enigma_pkg::*;
#(
  parameter int                    N_SYM    = 26,
  parameter int                    SYM_W    = 5,
  parameter int                    N_ROT    = 2,
  parameter logic [SYM_W*N_ROT-1:0] INIT_POS = '0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [SYM_W-1:0]       in_sym,
  input  logic                   in_rev,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [SYM_W-1:0]       out_sym,
  output logic                   out_err,
  input  logic                   cfg_we,
  input  logic [1:0]             cfg_idx,
  input  logic [SYM_W-1:0]       cfg_pos,
  output logic [SYM_W*N_ROT-1:0] pos_o
);

  localparam logic [SYM_W-1:0] NSYM_S = SYM_W'(N_SYM);
  localparam logic [SYM_W-1:0] NSYM_M1 = SYM_W'(N_SYM - 1);
  localparam logic [1:0]       LAST   = 2'(N_ROT - 1);

  state_t           state_q;
  logic [1:0]       stage_q;
  logic [SYM_W-1:0] sym_q;
  logic             rev_q;
  logic             err_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic [SYM_W-1:0] out_sym_q;
  logic             out_err_q;
  logic [SYM_W-1:0] pos_q [N_ROT];
  logic [SYM_W-1:0] pos_d [N_ROT];

  logic             accept;
  logic             sym_bad;
  logic             cfg_ok;
  logic [1:0]       rot_idx;
  logic [SYM_W-1:0] cur_pos;
  logic [SYM_W-1:0] stage_sym;
  logic             carry;

  assign accept  = (state_q == IDLE) && in_valid && in_ready_q;
  assign sym_bad = (in_sym == '0) || (in_sym > NSYM_S);
  assign cfg_ok  = cfg_we && ({1'b0, cfg_idx} < 3'(N_ROT)) && (cfg_pos < NSYM_S);

  // Reverse traversal walks the rotors from the top down.
  assign rot_idx = rev_q ? (LAST - stage_q) : stage_q;

  always_comb begin
    cur_pos = '0;
    for (int k = 0; k < N_ROT; k++) begin
      if (rot_idx == 2'(k)) cur_pos = pos_q[k];
    end
  end

  enigma_rotor_stage #(
    .N_SYM (N_SYM),
    .SYM_W (SYM_W)
  ) u_stage (
    .sym_i       (sym_q),
    .pos_i       (cur_pos),
    .rev_i       (rev_q),
    .rotor_sel_i (rot_idx),
    .sym_o       (stage_sym)
  );

  // Odometer step: a rotor advances only when every rotor below it wrapped.
  always_comb begin
    carry = 1'b1;
    for (int k = 0; k < N_ROT; k++) begin
      pos_d[k] = pos_q[k];
      if (carry) begin
        if (pos_q[k] == NSYM_M1) begin
          pos_d[k] = '0;
        end else begin
          pos_d[k] = pos_q[k] + SYM_W'(1);
          carry    = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      stage_q     <= '0;
      err_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_sym_q   <= '0;
      out_err_q   <= 1'b0;
      for (int k = 0; k < N_ROT; k++) pos_q[k] <= INIT_POS[k*SYM_W +: SYM_W];
    end else begin
      case (state_q)
        IDLE: begin
          // A same-edge accept sees the loaded position because stages start next cycle.
          if (cfg_ok) begin
            for (int k = 0; k < N_ROT; k++) begin
              if (cfg_idx == 2'(k)) pos_q[k] <= cfg_pos;
            end
          end
          if (accept) begin
            state_q    <= PASS;
            stage_q    <= '0;
            err_q      <= sym_bad;
            in_ready_q <= 1'b0;
          end
        end
        PASS: begin
          if (stage_q == LAST) begin
            state_q     <= OUT;
            out_valid_q <= 1'b1;
            out_sym_q   <= err_q ? '0 : stage_sym;
            out_err_q   <= err_q;
          end else begin
            stage_q <= stage_q + 2'd1;
          end
        end
        OUT: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            if (!out_err_q) begin
              for (int k = 0; k < N_ROT; k++) pos_q[k] <= pos_d[k];
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Symbol register: invalid symbols are carried through unchanged.
  always_ff @(posedge clk) begin
    if (accept) begin
      sym_q <= in_sym;
      rev_q <= in_rev;
    end else if (state_q == PASS && !err_q) begin
      sym_q <= stage_sym;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_sym   = out_sym_q;
  assign out_err   = out_err_q;

  for (genvar k = 0; k < N_ROT; k++) begin : g_pos
    assign pos_o[k*SYM_W +: SYM_W] = pos_q[k];
  end

endmodule

// File: tb/tb_enigma_rotor_stack.sv
module tb_enigma_rotor_stack;

  typedef struct {
    logic [4:0] sym;
    logic       err;
  } exp_t;

  localparam int W0 [26] = '{10, 7, 4,17,15,24,21,19, 3, 1,13, 9, 6,18,22,20,16,14, 5,23,11, 2,12,26,25, 8};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DUT A: single rotor, positions reset to 0
  logic       a_rst_n, a_in_valid, a_in_ready, a_in_rev, a_out_valid, a_out_ready, a_out_err, a_cfg_we;
  logic [4:0] a_in_sym, a_out_sym, a_cfg_pos, a_pos_o;
  logic [1:0] a_cfg_idx;
  // DUT B: two rotors, rotor0 reset to 25, rotor1 to 0
  logic       b_rst_n, b_in_valid, b_in_ready, b_in_rev, b_out_valid, b_out_ready, b_out_err, b_cfg_we;
  logic [4:0] b_in_sym, b_out_sym, b_cfg_pos;
  logic [9:0] b_pos_o;
  logic [1:0] b_cfg_idx;

  exp_t qa[$];
  exp_t qb[$];
  int n_tests = 0;
  int n_fail  = 0;

  enigma_rotor_stack #(.N_SYM(26), .SYM_W(5), .N_ROT(1), .INIT_POS(5'd0)) u_a (
    .clk(clk), .rst_n(a_rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_sym(a_in_sym), .in_rev(a_in_rev), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_sym(a_out_sym), .out_err(a_out_err), .cfg_we(a_cfg_we), .cfg_idx(a_cfg_idx),
    .cfg_pos(a_cfg_pos), .pos_o(a_pos_o)
  );

  enigma_rotor_stack #(.N_SYM(26), .SYM_W(5), .N_ROT(2), .INIT_POS(10'd25)) u_b (
    .clk(clk), .rst_n(b_rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_sym(b_in_sym), .in_rev(b_in_rev), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_sym(b_out_sym), .out_err(b_out_err), .cfg_we(b_cfg_we), .cfg_idx(b_cfg_idx),
    .cfg_pos(b_cfg_pos), .pos_o(b_pos_o)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int fwd_ref(input int s, input int p);
    int c;
    c = (s - 1 + p) % 26;
    return ((W0[c] - 1 - p + 26) % 26) + 1;
  endfunction

  // Monitors: pop and compare on every output handshake.
  always @(negedge clk) begin
    if (a_rst_n && a_out_valid && a_out_ready) begin
      if (qa.size() == 0) chk("a_unexpected_output", 1, 0);
      else begin
        exp_t e;
        e = qa.pop_front();
        chk("a_out_sym", int'(a_out_sym), int'(e.sym));
        chk("a_out_err", int'(a_out_err), int'(e.err));
      end
    end
  end

  always @(negedge clk) begin
    if (b_rst_n && b_out_valid && b_out_ready) begin
      if (qb.size() == 0) chk("b_unexpected_output", 1, 0);
      else begin
        exp_t e;
        e = qb.pop_front();
        chk("b_out_sym", int'(b_out_sym), int'(e.sym));
        chk("b_out_err", int'(b_out_err), int'(e.err));
      end
    end
  end

  // Issue one symbol (optionally with a coincident cfg write); returns #1 after the accept edge.
  task automatic send(input int d, input int sym, input bit rev, input bit cfg_en,
                      input int cidx, input int cpos, input int exp_sym, input bit exp_err,
                      input bit push);
    int   t;
    exp_t e;
    t = 0;
    while (!(d == 0 ? a_in_ready : b_in_ready) && t < 50) begin
      @(posedge clk); #1; t++;
    end
    if (t >= 50) chk("send_ready_timeout", 1, 0);
    e.sym = exp_sym[4:0];
    e.err = exp_err;
    if (d == 0) begin
      a_in_valid = 1'b1; a_in_sym = sym[4:0]; a_in_rev = rev;
      a_cfg_we = cfg_en; a_cfg_idx = cidx[1:0]; a_cfg_pos = cpos[4:0];
      if (push) qa.push_back(e);
    end else begin
      b_in_valid = 1'b1; b_in_sym = sym[4:0]; b_in_rev = rev;
      b_cfg_we = cfg_en; b_cfg_idx = cidx[1:0]; b_cfg_pos = cpos[4:0];
      if (push) qb.push_back(e);
    end
    @(posedge clk); #1;
    a_in_valid = 1'b0; a_cfg_we = 1'b0;
    b_in_valid = 1'b0; b_cfg_we = 1'b0;
  endtask

  // Wait until the scoreboard has drained; returns #1 after the handshake edge.
  task automatic wait_done(input int d);
    int t;
    t = 0;
    while ((d == 0 ? qa.size() : qb.size()) != 0 && t < 50) begin
      @(posedge clk); #1; t++;
    end
    if (t >= 50) chk("wait_output_timeout", 1, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    a_rst_n = 1'b0; a_in_valid = 1'b0; a_in_sym = '0; a_in_rev = 1'b0; a_out_ready = 1'b1;
    a_cfg_we = 1'b0; a_cfg_idx = '0; a_cfg_pos = '0;
    b_rst_n = 1'b0; b_in_valid = 1'b0; b_in_sym = '0; b_in_rev = 1'b0; b_out_ready = 1'b1;
    b_cfg_we = 1'b0; b_cfg_idx = '0; b_cfg_pos = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("a_rst_in_ready", a_in_ready, 1);
    chk("a_rst_out_valid", a_out_valid, 0);
    chk("a_rst_out_sym", a_out_sym, 0);
    chk("a_rst_out_err", a_out_err, 0);
    chk("a_rst_pos", a_pos_o, 0);
    chk("b_rst_pos", b_pos_o, 25);
    chk("b_rst_in_ready", b_in_ready, 1);
    a_rst_n = 1'b1; b_rst_n = 1'b1;
    @(posedge clk); #1;

    // ---------------- single rotor ----------------
    send(0, 1, 0, 0, 0, 0, 10, 0, 1);
    chk("a_lat_e0_valid", a_out_valid, 0);
    @(posedge clk); #1;
    chk("a_lat_e1_valid", a_out_valid, 1);
    wait_done(0);
    chk("a_pos_after_1", a_pos_o, 1);
    send(0, 1, 0, 0, 0, 0, 6, 0, 1);
    wait_done(0);
    chk("a_pos_after_2", a_pos_o, 2);
    send(0, 10, 1, 1, 0, 0, 1, 0, 1);
    wait_done(0);
    chk("a_pos_after_rev", a_pos_o, 1);

    send(0, 0, 0, 0, 0, 0, 0, 1, 1);
    wait_done(0);
    chk("a_pos_after_sym0", a_pos_o, 1);
    send(0, 27, 0, 0, 0, 0, 0, 1, 1);
    wait_done(0);
    chk("a_pos_after_sym27", a_pos_o, 1);
    send(0, 31, 1, 0, 0, 0, 0, 1, 1);
    wait_done(0);
    chk("a_pos_after_sym31", a_pos_o, 1);

    a_cfg_we = 1'b1; a_cfg_idx = 2'd0; a_cfg_pos = 5'd26;
    @(posedge clk); #1;
    a_cfg_we = 1'b0;
    chk("a_cfg_pos_range_ignored", a_pos_o, 1);
    a_cfg_we = 1'b1; a_cfg_idx = 2'd0; a_cfg_pos = 5'd25;
    @(posedge clk); #1;
    a_cfg_we = 1'b0;
    chk("a_cfg_load", a_pos_o, 25);

    // Output stall with a cfg write attempted during OUT
    a_out_ready = 1'b0;
    send(0, 2, 0, 0, 0, 0, 11, 0, 1);
    begin
      int t;
      t = 0;
      while (!a_out_valid && t < 20) begin @(posedge clk); #1; t++; end
      if (t >= 20) chk("a_stall_valid_timeout", 1, 0);
    end
    for (int i = 0; i < 5; i++) begin
      chk("a_stall_valid", a_out_valid, 1);
      chk("a_stall_sym", a_out_sym, 11);
      chk("a_stall_pos", a_pos_o, 25);
      chk("a_stall_in_ready", a_in_ready, 0);
      a_cfg_we = (i == 1); a_cfg_idx = 2'd0; a_cfg_pos = 5'd20;
      @(posedge clk); #1;
    end
    a_cfg_we = 1'b0;
    a_out_ready = 1'b1;
    wait_done(0);
    chk("a_pos_after_stall_wrap", a_pos_o, 0);

    // Round trip at position 7 over the whole alphabet
    for (int s = 1; s <= 26; s++) begin
      int e;
      e = fwd_ref(s, 7);
      send(0, s, 0, 1, 0, 7, e, 0, 1);
      wait_done(0);
      send(0, e, 1, 1, 0, 7, s, 0, 1);
      wait_done(0);
    end

    // ---------------- two rotors ----------------
    send(1, 1, 0, 0, 0, 0, 11, 0, 1);
    chk("b_lat_e0_valid", b_out_valid, 0);
    chk("b_busy_in_ready", b_in_ready, 0);
    @(posedge clk); #1;
    chk("b_lat_e1_valid", b_out_valid, 0);
    @(posedge clk); #1;
    chk("b_lat_e2_valid", b_out_valid, 1);
    wait_done(1);
    chk("b_pos_carry", b_pos_o, 32);
    chk("b_ready_back", b_in_ready, 1);
    send(1, 1, 0, 0, 0, 0, 22, 0, 1);
    wait_done(1);
    chk("b_pos_second", b_pos_o, 33);
    send(1, 22, 1, 1, 0, 0, 1, 0, 1);
    wait_done(1);
    chk("b_pos_after_rev", b_pos_o, 33);
    b_cfg_we = 1'b1; b_cfg_idx = 2'd2; b_cfg_pos = 5'd3;
    @(posedge clk); #1;
    b_cfg_we = 1'b0;
    chk("b_cfg_idx_range_ignored", b_pos_o, 33);

    // Reset during PASS discards the symbol
    send(1, 5, 0, 0, 0, 0, 0, 0, 0);
    b_rst_n = 1'b0;
    @(posedge clk); #1;
    b_rst_n = 1'b1;
    chk("b_rst_pass_valid", b_out_valid, 0);
    chk("b_rst_pass_ready", b_in_ready, 1);
    chk("b_rst_pass_pos", b_pos_o, 25);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk("b_rst_no_output", b_out_valid, 0);
    end

    chk("a_queue_drained", qa.size(), 0);
    chk("b_queue_drained", qb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
